fifo_sync_ctrl: RTL and testbench

//  Single-clock controller that sequences one fifomem instance (wclk and rclk both tied to clk).

---
 rtl/fifo_sync_ctrl_pkg.sv | 16 +
 rtl/fifo_sync_ctrl_arb.sv | 50 +++++
 rtl/fifo_sync_ctrl.sv | 139 +++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared sizing helpers for the single-clock FIFO controller.
// Pointers carry one extra wrap bit above the memory address. This lets
// occupancy range over 0..depth inclusive without a separate flag.
package fifo_sync_ctrl_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Number of words in the attached memory.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_arb.sv
// Round-robin arbiter that shares one push port among N requesters.
// Latency: the grant is combinational from req/enable. The priority pointer updates at the granting edge.
// Backpressure: with enable low, no grant is issued and the priority holds.
//
// Ports:
//   clk, rst_n  clock, async active-low reset (priority returns to requester 0)
//   req         per-requester request
//   enable      allows a grant this cycle (low when the FIFO cannot accept)
//   gnt         one-hot grant, all zero when nothing is granted
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] prio;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // Scan requesters starting at the current priority index, wrapping
    // around. The first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (enable && !found && req[(int'(prio) + k) % N]) begin
                found                      = 1'b1;
                gnt[(int'(prio) + k) % N]  = 1'b1;
                gnt_idx                    = PW'((int'(prio) + k) % N);
            end
        end
    end

    // The requester after the winner gets first look next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (found) begin
            prio <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: arbitrates N producers onto one fifomem, tracks pointers and flags.
// Latency: a push or pop is accepted in the same cycle. Popped data appears on mem rdata one cycle later, with rd_valid.
// Backpressure: while full, wr_gnt stays 0 and requesters hold. rd_req while empty is ignored.
//
// Optional feature macro: FIFO_SYNC_CTRL_ERR_EN adds sticky overflow/underflow outputs.
//
// Ports:
//   clk, rst_n            clock (also drives fifomem wclk/rclk), async active-low reset
//   wr_req/wr_data        per-requester push request and data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   wr_gnt                one-hot push acceptance, combinational
//   rd_req                pop request
//   rd_valid              registered; high while fifomem rdata holds the popped word
//   full/empty/almost_full/count   occupancy status, combinational from the pointer registers
//   mem_*                 fifomem write/read port controls
//   overflow/underflow    (FIFO_SYNC_CTRL_ERR_EN only) sticky error flags, cleared by reset
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    parameter int AF_LEVEL   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]            wr_gnt,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          mem_wclken,
    output logic [ADDR_WIDTH-1:0]         mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_rclken,
    output logic [ADDR_WIDTH-1:0]         mem_raddr,
    output logic                          mem_wfull,
    output logic                          mem_rempty
`ifdef FIFO_SYNC_CTRL_ERR_EN
    ,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(fifo_depth(ADDR_WIDTH));
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic                  arb_en;
    logic                  push;
    logic                  pop;

    // Occupancy comes straight from the registered pointers. Modulo
    // subtraction handles wrap, because the extra pointer bit tells
    // full apart from empty.
    assign count       = wptr - rptr;
    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_CNT);

    // Gating with rst_n keeps wr_gnt low for the whole reset, even if
    // requesters are still asserting.
    assign arb_en = !full && rst_n;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_req),
        .enable (arb_en),
        .gnt    (wr_gnt)
    );

    // Because wr_gnt is one-hot, the data mux is a simple priority-free select.
    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wdata_mux = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign push = |wr_gnt;
    assign pop  = rd_req && !empty;

    assign mem_wclken = push;
    assign mem_waddr  = wptr[ADDR_WIDTH-1:0];
    assign mem_wdata  = wdata_mux;
    assign mem_rclken = pop;
    assign mem_raddr  = rptr[ADDR_WIDTH-1:0];
    assign mem_wfull  = full;
    assign mem_rempty = empty;

    // rd_valid follows the read-enable by one cycle, which is exactly when
    // fifomem presents the addressed word on rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            rd_valid <= pop;
        end
    end

`ifdef FIFO_SYNC_CTRL_ERR_EN
    // Sticky flags record any attempt against a full or empty FIFO,
    // even though the controller refuses that attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if ((|wr_req) && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int N     = 2;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    wr_req;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    wr_gnt;
    logic            rd_req;
    logic            rd_valid;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic [AW:0]     count;
    logic            mem_wclken;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rclken;
    logic [AW-1:0]   mem_raddr;
    logic            mem_wfull;
    logic            mem_rempty;
`ifdef FIFO_SYNC_CTRL_ERR_EN
    logic            overflow;
    logic            underflow;
`endif

    fifo_sync_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (N),
        .AF_LEVEL   (AFL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .mem_wclken  (mem_wclken),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_rclken  (mem_rclken),
        .mem_raddr   (mem_raddr),
        .mem_wfull   (mem_wfull),
        .mem_rempty  (mem_rempty)
`ifdef FIFO_SYNC_CTRL_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial forever #5 clk = ~clk;

    // Stand-in for fifomem: a synchronous write and a registered read.
    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] rdata;
    always @(posedge clk) begin
        if (mem_wclken) mem_arr[mem_waddr] <= mem_wdata;
        if (mem_rclken) rdata <= mem_arr[mem_raddr];
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a data queue, push/pop counters and a round-robin index.
    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    int  prio_m = 0;
    int  wcnt   = 0;
    int  rcnt   = 0;
    bit  pv     = 1'b0;
    logic [DW-1:0] pd;
    bit  ov_m   = 1'b0;
    bit  un_m   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_full", 32'(full), 32'd0);
            chk("rst_af", 32'(almost_full), 32'd0);
            chk("rst_gnt", 32'(wr_gnt), 32'd0);
            chk("rst_wclken", 32'(mem_wclken), 32'd0);
            chk("rst_rclken", 32'(mem_rclken), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_SYNC_CTRL_ERR_EN
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_underflow", 32'(underflow), 32'd0);
`endif
            q.delete();
            prio_m = 0; wcnt = 0; rcnt = 0; pv = 1'b0; ov_m = 1'b0; un_m = 1'b0;
        end else begin
            int  cnt;
            int  g;
            bit  pop;
            cnt = q.size();
            g   = -1;
            if (cnt < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && wr_req[(prio_m + k) % N]) g = (prio_m + k) % N;
                end
            end
            pop = rd_req && (cnt > 0);

            chk("count", 32'(count), 32'(cnt));
            chk("full", 32'(full), 32'(cnt == DEPTH));
            chk("empty", 32'(empty), 32'(cnt == 0));
            chk("almost_full", 32'(almost_full), 32'(cnt >= AFL));
            chk("mem_wfull", 32'(mem_wfull), 32'(cnt == DEPTH));
            chk("mem_rempty", 32'(mem_rempty), 32'(cnt == 0));
            chk("wr_gnt", 32'(wr_gnt), (g < 0) ? 32'd0 : (32'd1 << g));
            chk("mem_wclken", 32'(mem_wclken), 32'(g >= 0));
            if (g >= 0) begin
                chk("mem_wdata", 32'(mem_wdata), 32'(wr_data[g*DW +: DW]));
                chk("mem_waddr", 32'(mem_waddr), 32'(wcnt % DEPTH));
            end
            chk("mem_rclken", 32'(mem_rclken), 32'(pop));
            if (pop) chk("mem_raddr", 32'(mem_raddr), 32'(rcnt % DEPTH));
            chk("rd_valid", 32'(rd_valid), 32'(pv));
            if (pv) begin
                chk("rdata", 32'(rdata), 32'(pd));
                got.push_back(rdata);
            end
`ifdef FIFO_SYNC_CTRL_ERR_EN
            chk("overflow", 32'(overflow), 32'(ov_m));
            chk("underflow", 32'(underflow), 32'(un_m));
            if ((wr_req != '0) && cnt == DEPTH) ov_m = 1'b1;
            if (rd_req && cnt == 0) un_m = 1'b1;
`endif
            if (pop) begin
                pd = q.pop_front();
                rcnt++;
            end
            pv = pop;
            if (g >= 0) begin
                q.push_back(wr_data[g*DW +: DW]);
                wcnt++;
                prio_m = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_req = '0; rd_req = 1'b0; wr_data = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic push_n(input logic [DW-1:0] base, input int n);
        wr_req = 2'b01;
        for (int k = 0; k < n; k++) begin
            wr_data[DW-1:0] = base + DW'(k);
            step();
        end
        wr_req = '0;
    endtask

    task automatic drain();
        rd_req = 1'b1;
        repeat (DEPTH + 1) step();
        rd_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        int n0, n1;

        // 1: fill from requester 0 until full, then one refused request
        do_reset();
        chk("t1_count0", 32'(count), 32'd0);
        wr_req = 2'b01;
        for (int k = 0; k < DEPTH; k++) begin
            wr_data[DW-1:0] = DW'(k);
            step();
            if (k == 10) chk("t1_af_at11", 32'(almost_full), 32'd0);
            if (k == 11) chk("t1_af_at12", 32'(almost_full), 32'd1);
        end
        chk("t1_count16", 32'(count), 32'd16);
        chk("t1_full", 32'(full), 32'd1);
        wr_data[DW-1:0] = 8'h10;
        #1;
        chk("t1_gnt_full", 32'(wr_gnt), 32'd0);
        chk("t1_wclken_full", 32'(mem_wclken), 32'd0);
        step();
        wr_req = '0;
        drain();

        // 2: both requesters hold their requests; grants must alternate
        do_reset();
        got.delete();
        wr_req = 2'b11; n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            wr_data = {8'hB0 + DW'(n1), 8'hA0 + DW'(n0)};
            #1;
            g = wr_gnt;
            if (c < 4) chk("t2_gnt_alt", 32'(g), (c % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            n0 += int'(g[0]);
            n1 += int'(g[1]);
        end
        wr_req = '0;
        drain();
        chk("t2_npop", 32'(got.size()), 32'd8);
        if (got.size() >= 4) begin
            chk("t2_pop0", 32'(got[0]), 32'hA0);
            chk("t2_pop1", 32'(got[1]), 32'hB0);
            chk("t2_pop2", 32'(got[2]), 32'hA1);
            chk("t2_pop3", 32'(got[3]), 32'hB1);
        end

        // 3: when full, a pop is accepted and a same-cycle push is refused
        push_n(8'hC0, DEPTH);
        wr_req = 2'b01; wr_data[DW-1:0] = 8'hD0; rd_req = 1'b1;
        #1;
        chk("t3_gnt_refused", 32'(wr_gnt), 32'd0);
        chk("t3_rclken", 32'(mem_rclken), 32'd1);
        step();
        rd_req = 1'b0;
        #1;
        chk("t3_gnt_next", 32'(wr_gnt), 32'd1);
        step();
        wr_req = '0;
        chk("t3_count16", 32'(count), 32'd16);
        drain();

        // 4: when empty, a push is accepted and a same-cycle pop is refused
        wr_req = 2'b01; wr_data[DW-1:0] = 8'h5A; rd_req = 1'b1;
        #1;
        chk("t4_rclken_empty", 32'(mem_rclken), 32'd0);
        chk("t4_gnt", 32'(wr_gnt), 32'd1);
        step();
        wr_req = '0;
        #1;
        chk("t4_rclken_next", 32'(mem_rclken), 32'd1);
        step();
        rd_req = 1'b0;
        chk("t4_rd_valid", 32'(rd_valid), 32'd1);
        chk("t4_rdata", 32'(rdata), 32'h5A);
        chk("t4_empty", 32'(empty), 32'd1);
        step();

        // 5: steady push/pop at occupancy 3 across pointer wraps
        push_n(8'h30, 3);
        wr_req = 2'b01; rd_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_data[DW-1:0] = 8'h40 + DW'(k);
            step();
        end
        wr_req = '0; rd_req = 1'b0;
        chk("t5_count3", 32'(count), 32'd3);
        drain();

        // 6: asynchronous reset mid-burst
        push_n(8'h70, 7);
        chk("t6_count7", 32'(count), 32'd7);
        wr_req = 2'b01; wr_data[DW-1:0] = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_gnt", 32'(wr_gnt), 32'd0);
        chk("t6_rst_wclken", 32'(mem_wclken), 32'd0);
        chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        wr_req = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
`ifdef FIFO_SYNC_CTRL_ERR_EN
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t6_underflow_set", 32'(underflow), 32'd1);
        step();
        chk("t6_underflow_sticky", 32'(underflow), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_underflow_clr", 32'(underflow), 32'd0);
        step();
        rst_n = 1'b1;
        step();
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
